// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: pass/fail monitor for riscv-tests ISA programs.
// Snoops the register-file write-back port, shadows the test-number and
// pass registers, detects the end-of-test marker (DONE_REG written with 1),
// waits a settle window and latches a verdict. A watchdog produces a timeout
// verdict if no marker arrives; clear restarts monitoring for the next image.
//
// Optional feature: define TEST_MON_SIG_EN to add the `signature` output, an
// XOR-rotate accumulation over every qualified write-back seen in RUN.
//
// Ports:
//   clk           clock
//   rst           asynchronous reset, active-low
//   clear         synchronous restart (priority over everything but rst)
//   wb_en         register-file write enable
//   wb_addr       register-file write address
//   wb_data       register-file write data
//   done          verdict valid
//   pass          PASS_REG shadow equalled 1 at sample time
//   fail          verdict was fail or timeout
//   timeout       watchdog expired
//   fail_testnum  TESTNUM_REG shadow captured at the verdict
//   cycle_count   cycles spent in RUN and SETTLE (saturating)
//   signature     (TEST_MON_SIG_EN only) write-back signature
module riscv_test_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned PASS_REG       = 27,
  parameter int unsigned TESTNUM_REG    = 3,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  fail_testnum,
  output logic [CNT_W-1:0] cycle_count
`ifdef TEST_MON_SIG_EN
  ,
  output logic [XLEN-1:0]  signature
`endif
);

  localparam int unsigned SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_VERDICT = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [XLEN-1:0]   tn_sh_q, tn_sh_d;
  logic [XLEN-1:0]   pass_sh_q, pass_sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   tn_q, tn_d;

  logic              wr_ok;
  logic              done_mark;
  logic              wdog_hit;
  logic [CNT_W-1:0]  cnt_inc;

  // Qualified write: x0 writes are architectural no-ops and never count.
  assign wr_ok     = wb_en && (wb_addr != 5'd0);
  assign done_mark = wr_ok && (wb_addr == 5'(DONE_REG)) && (wb_data == XLEN'(1));
  assign wdog_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef TEST_MON_SIG_EN
  logic [XLEN-1:0] sig_q, sig_d;
  logic [XLEN-1:0] data_ext;

  // Fold the register index into the top bits so equal data to different
  // registers produces different contributions.
  assign data_ext = wb_data ^ (XLEN'(wb_addr) << (XLEN - 5));
`endif

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    tn_sh_d   = tn_sh_q;
    pass_sh_d = pass_sh_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    tn_d      = tn_q;
`ifdef TEST_MON_SIG_EN
    sig_d     = sig_q;
`endif

    if (clear) begin
      state_d   = ST_RUN;
      settle_d  = '0;
      tn_sh_d   = '0;
      pass_sh_d = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      tn_d      = '0;
`ifdef TEST_MON_SIG_EN
      sig_d     = '0;
`endif
    end else begin
      // Shadows track write-back only while the test is still live.
      if ((state_q == ST_RUN || state_q == ST_SETTLE) && wr_ok) begin
        if (wb_addr == 5'(TESTNUM_REG)) tn_sh_d = wb_data;
        if (wb_addr == 5'(PASS_REG))    pass_sh_d = wb_data;
      end

      case (state_q)
        ST_RUN: begin
`ifdef TEST_MON_SIG_EN
          if (wr_ok) sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ data_ext;
`endif
          // The end-of-test marker wins over a watchdog expiring the same cycle.
          if (done_mark) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            cnt_d    = cnt_inc;
          end else if (wdog_hit) begin
            state_d   = ST_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            fail_d    = 1'b1;
            pass_d    = 1'b0;
            tn_d      = tn_sh_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_SETTLE: begin
          cnt_d = cnt_inc;
          // Marker edge plus SETTLE_CYCLES settle cycles before sampling.
          if (settle_q == SC_W'(SETTLE_CYCLES)) begin
            state_d = ST_VERDICT;
            done_d  = 1'b1;
            pass_d  = (pass_sh_q == XLEN'(1));
            fail_d  = (pass_sh_q != XLEN'(1));
            tn_d    = tn_sh_q;
          end else begin
            settle_d = settle_q + SC_W'(1);
          end
        end

        default: begin
          // VERDICT and TIMEOUT hold until clear or reset.
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      settle_q  <= '0;
      tn_sh_q   <= '0;
      pass_sh_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      tn_q      <= '0;
`ifdef TEST_MON_SIG_EN
      sig_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      tn_sh_q   <= tn_sh_d;
      pass_sh_q <= pass_sh_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      tn_q      <= tn_d;
`ifdef TEST_MON_SIG_EN
      sig_q     <= sig_d;
`endif
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign fail_testnum = tn_q;
  assign cycle_count  = cnt_q;
`ifdef TEST_MON_SIG_EN
  assign signature    = sig_q;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor: randomized write-back traffic
// checked against a register-array reference model of the monitor rules.
module tb_riscv_test_monitor;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SETTLE = 10;
  localparam int unsigned TMO    = 50;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SAT_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             done, pass, fail, timeout;
  logic [XLEN-1:0]  fail_testnum;
  logic [CNT_W-1:0] cycle_count;
`ifdef TEST_MON_SIG_EN
  logic [XLEN-1:0]  signature;
  logic [XLEN-1:0]  sat_signature;
`endif

  // Second instance: watchdog disabled, narrow counter, idle write-back.
  logic             sat_clear = 1'b0;
  logic             sat_wb_en = 1'b0;
  logic [4:0]       sat_wb_addr = 5'd0;
  logic [XLEN-1:0]  sat_wb_data = '0;
  logic             sat_done, sat_pass, sat_fail, sat_timeout;
  logic [XLEN-1:0]  sat_tn;
  logic [SAT_W-1:0] sat_cnt;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .XLEN(XLEN), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_testnum(fail_testnum), .cycle_count(cycle_count)
`ifdef TEST_MON_SIG_EN
    , .signature(signature)
`endif
  );

  riscv_test_monitor #(
    .XLEN(XLEN), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(0), .CNT_W(SAT_W)
  ) u_sat (
    .clk(clk), .rst(rst), .clear(sat_clear), .wb_en(sat_wb_en),
    .wb_addr(sat_wb_addr), .wb_data(sat_wb_data), .done(sat_done),
    .pass(sat_pass), .fail(sat_fail), .timeout(sat_timeout),
    .fail_testnum(sat_tn), .cycle_count(sat_cnt)
`ifdef TEST_MON_SIG_EN
    , .signature(sat_signature)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural register values seen since restart,
  // the expected signature and the number of counted cycles.
  logic [XLEN-1:0] m_regs [32];
  logic [XLEN-1:0] m_sig;
  int              m_cnt;

  // Snapshot of a latched verdict, used to check it holds.
  logic            s_done, s_pass, s_fail, s_to;
  logic [XLEN-1:0] s_tn;
  int              s_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_sig = '0;
    m_cnt = 0;
  endtask

  // One clock: drive a write-back, let the edge happen, update the model.
  // live: the monitor accepts writes; run: writes enter the signature;
  // cnt: this edge is a counted cycle.
  task automatic tick(input logic en, input logic [4:0] a, input logic [XLEN-1:0] d,
                      input bit live, input bit run, input bit cnt);
    logic [XLEN-1:0] ext;
    wb_en = en; wb_addr = a; wb_data = d;
    @(posedge clk);
    if (live && en && a != 5'd0) begin
      m_regs[a] = d;
      if (run) begin
        ext   = d ^ (XLEN'(a) << (XLEN - 5));
        m_sig = {m_sig[XLEN-2:0], m_sig[XLEN-1]} ^ ext;
      end
    end
    if (cnt) m_cnt++;
    #1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = '0;
  endtask

  task automatic rnd_stim(input bit allow_mark, output logic en, output logic [4:0] a,
                          output logic [XLEN-1:0] d);
    en = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 5))
      0: a = 5'd3;
      1: a = 5'd27;
      2: a = 5'd26;
      3: a = 5'd0;
      default: a = 5'($urandom_range(0, 31));
    endcase
    case ($urandom_range(0, 3))
      0: d = '0;
      1: d = XLEN'(1);
      default: d = XLEN'($urandom);
    endcase
    if (!allow_mark && en && a == 5'd26 && d == XLEN'(1)) d = XLEN'(2);
  endtask

  task automatic check_all(input string pfx, input logic e_done, input logic e_pass,
                           input logic e_fail, input logic e_to,
                           input logic [XLEN-1:0] e_tn, input int e_cnt);
    check({pfx, "_done"}, 64'(done), 64'(e_done));
    check({pfx, "_pass"}, 64'(pass), 64'(e_pass));
    check({pfx, "_fail"}, 64'(fail), 64'(e_fail));
    check({pfx, "_timeout"}, 64'(timeout), 64'(e_to));
    check({pfx, "_testnum"}, 64'(fail_testnum), 64'(e_tn));
    check({pfx, "_count"}, 64'(cycle_count), 64'(e_cnt));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    check_all("clear", 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
`ifdef TEST_MON_SIG_EN
    check("clear_sig", 64'(signature), 64'(0));
`endif
  endtask

  // Settle window after the marker edge, optional late PASS_REG write at
  // settle cycle late_k (0 = none), then the verdict edge.
  task automatic settle_and_verdict(input int late_k, input logic [XLEN-1:0] late_val,
                                    input bit rnd);
    logic en; logic [4:0] a; logic [XLEN-1:0] d;
    logic e_pass;
    for (int k = 1; k <= int'(SETTLE); k++) begin
      if (k == late_k) tick(1'b1, 5'd27, late_val, 1'b1, 1'b0, 1'b1);
      else if (rnd) begin
        rnd_stim(1'b0, en, a, d);
        tick(en, a, d, 1'b1, 1'b0, 1'b1);
      end else tick(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);
      check("settle_done_low", 64'(done), 64'(0));
    end
    tick(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);
    e_pass = (m_regs[27] == XLEN'(1));
    check_all("verdict", 1'b1, e_pass, !e_pass, 1'b0, m_regs[3], m_cnt);
`ifdef TEST_MON_SIG_EN
    check("verdict_sig", 64'(signature), 64'(m_sig));
`endif
    s_done = 1'b1; s_pass = e_pass; s_fail = !e_pass; s_to = 1'b0;
    s_tn = m_regs[3]; s_cnt = m_cnt;
  endtask

  // Random traffic (markers included) must not disturb a latched verdict.
  task automatic hold_check();
    logic en; logic [4:0] a; logic [XLEN-1:0] d;
    for (int i = 0; i < 3; i++) begin
      rnd_stim(1'b1, en, a, d);
      tick(en, a, d, 1'b0, 1'b0, 1'b0);
    end
    check_all("hold", s_done, s_pass, s_fail, s_to, s_tn, s_cnt);
`ifdef TEST_MON_SIG_EN
    check("hold_sig", 64'(signature), 64'(m_sig));
`endif
  endtask

  task automatic run_random(input int n);
    logic en; logic [4:0] a; logic [XLEN-1:0] d;
    int late_k;
    do_clear();
    for (int i = 1; i < n; i++) begin
      rnd_stim(1'b0, en, a, d);
      tick(en, a, d, 1'b1, 1'b1, 1'b1);
      if (i == n - 1) check("run_done_low", 64'(done), 64'(0));
    end
    tick(1'b1, 5'd26, XLEN'(1), 1'b1, 1'b1, 1'b1);
    late_k = $urandom_range(0, SETTLE);
    settle_and_verdict(late_k, XLEN'($urandom_range(0, 1)), 1'b1);
    hold_check();
  endtask

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic en; logic [4:0] a; logic [XLEN-1:0] d;

    rst = 1'b0; clear = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = '0;
    model_reset();
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
    #11;
    rst = 1'b1;

    // Counting from reset, and saturation of the narrow counter.
    for (int i = 0; i < 3; i++) tick(1'b0, 5'd0, '0, 1'b1, 1'b1, 1'b1);
    check("run_count", 64'(cycle_count), 64'(m_cnt));
    check("sat_count_early", 64'(sat_cnt), 64'(3));
    for (int i = 0; i < 27; i++) tick(1'b0, 5'd0, '0, 1'b1, 1'b1, 1'b1);
    check("run_count_30", 64'(cycle_count), 64'(30));
    check("sat_count_sat", 64'(sat_cnt), 64'(15));
    check("sat_no_timeout", 64'({sat_done, sat_timeout}), 64'(0));

    // Pass path.
    do_clear();
    tick(1'b1, 5'd3, XLEN'(5), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd27, XLEN'(1), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd26, XLEN'(1), 1'b1, 1'b1, 1'b1);
    settle_and_verdict(0, '0, 1'b0);
    check("pass_path_pass", 64'(pass), 64'(1));
    check("pass_path_tn", 64'(fail_testnum), 64'(5));
    hold_check();

    // Fail path rescued by a late pass write, then a plain fail.
    do_clear();
    tick(1'b1, 5'd3, XLEN'(7), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd27, XLEN'(0), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd26, XLEN'(1), 1'b1, 1'b1, 1'b1);
    settle_and_verdict(4, XLEN'(1), 1'b0);
    check("late_pass", 64'(pass), 64'(1));
    do_clear();
    tick(1'b1, 5'd3, XLEN'(7), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd27, XLEN'(0), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd26, XLEN'(1), 1'b1, 1'b1, 1'b1);
    settle_and_verdict(0, '0, 1'b0);
    check("fail_path_fail", 64'(fail), 64'(1));
    check("fail_path_tn", 64'(fail_testnum), 64'(7));

    // Writes that must not be taken as the end-of-test marker.
    do_clear();
    tick(1'b1, 5'd26, XLEN'(2), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd0, XLEN'(1), 1'b1, 1'b1, 1'b1);
    tick(1'b0, 5'd26, XLEN'(1), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < int'(SETTLE) + 3; i++) tick(1'b0, 5'd0, '0, 1'b1, 1'b1, 1'b1);
    check("ignored_done", 64'(done), 64'(0));
    check("ignored_count", 64'(cycle_count), 64'(m_cnt));

    // Watchdog: expires on the 50th cycle with the count held at 49.
    do_clear();
    for (int i = 1; i < int'(TMO); i++) begin
      rnd_stim(1'b0, en, a, d);
      tick(en, a, d, 1'b1, 1'b1, 1'b1);
    end
    check("tmo_before_done", 64'(done), 64'(0));
    tick(1'b0, 5'd0, '0, 1'b1, 1'b1, 1'b0);
    check_all("tmo", 1'b1, 1'b0, 1'b1, 1'b1, m_regs[3], int'(TMO) - 1);
`ifdef TEST_MON_SIG_EN
    check("tmo_sig", 64'(signature), 64'(m_sig));
`endif
    s_done = 1'b1; s_pass = 1'b0; s_fail = 1'b1; s_to = 1'b1;
    s_tn = m_regs[3]; s_cnt = int'(TMO) - 1;
    hold_check();

    // Randomized tests; the first lands the marker on the watchdog cycle.
    for (int t = 0; t < 12; t++) run_random((t == 0) ? int'(TMO) : int'($urandom_range(1, TMO)));

    // Asynchronous reset in the middle of SETTLE.
    do_clear();
    tick(1'b1, 5'd27, XLEN'(1), 1'b1, 1'b1, 1'b1);
    tick(1'b1, 5'd26, XLEN'(1), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_all("rst_settle", 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
    #3 rst = 1'b1;
    model_reset();
    for (int i = 0; i < int'(SETTLE) + 5; i++) begin
      tick(1'b0, 5'd0, '0, 1'b1, 1'b1, 1'b1);
      check("rst_no_done", 64'(done), 64'(0));
    end
    check("rst_count", 64'(cycle_count), 64'(m_cnt));

    // Asynchronous reset while a verdict is latched.
    run_random(5);
    #2 rst = 1'b0;
    #1;
    check_all("rst_verdict", 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
    #3 rst = 1'b1;
    model_reset();

`ifdef TEST_MON_SIG_EN
    // Fixed signature sequence: x1=1 then x2=2.
    do_clear();
    tick(1'b1, 5'd1, XLEN'(1), 1'b1, 1'b1, 1'b1);
    check("sig_x1", 64'(signature), 64'(32'h0800_0001));
    tick(1'b1, 5'd2, XLEN'(2), 1'b1, 1'b1, 1'b1);
    check("sig_x2", 64'(signature), 64'(32'h0000_0000));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
